// File: rtl/read_iq.sv
// read_iq: assembles little-endian interleaved I/Q byte pairs from an 8-bit
// FWFT FIFO, sign-extends and quantizes them, and writes each I/Q pair to the
// i_in and q_in sample FIFOs in the same cycle.
module read_iq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned BITS       = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] i_din,
  output logic                  i_wr_en,
  input  logic                  i_full,
  output logic [DATA_WIDTH-1:0] q_din,
  output logic                  q_wr_en,
  input  logic                  q_full,
  output logic [31:0]           sample_count
);

  localparam int unsigned SAMPLE_W = 2 * BYTE_WIDTH;
  localparam int unsigned CNT_W    = 2;

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      byte_cnt;
  logic [BYTE_WIDTH-1:0] byte0;
  logic [BYTE_WIDTH-1:0] byte1;
  logic [BYTE_WIDTH-1:0] byte2;
  logic                  wr_go;

  // Sign-extend a raw 16-bit sample to DATA_WIDTH, then shift; overflow bits drop.
  function automatic logic [DATA_WIDTH-1:0] quantize(input logic [SAMPLE_W-1:0] s);
    logic [DATA_WIDTH-1:0] ext;
    ext = {{(DATA_WIDTH - SAMPLE_W){s[SAMPLE_W-1]}}, s};
    return ext << BITS;
  endfunction

  // Handshake enables: read only while assembling, write both FIFOs together.
  always_comb begin
    in_rd_en = 1'b0;
    wr_go    = 1'b0;
    if (!reset) begin
      in_rd_en = (state == S_READ) && !in_empty;
      wr_go    = (state == S_WRITE) && !i_full && !q_full;
    end
  end

  assign i_wr_en = wr_go;
  assign q_wr_en = wr_go;

  // Byte assembly, sample quantization and pair counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_READ;
      byte_cnt     <= '0;
      byte0        <= '0;
      byte1        <= '0;
      byte2        <= '0;
      i_din        <= '0;
      q_din        <= '0;
      sample_count <= '0;
    end else begin
      case (state)
        S_READ: begin
          if (in_rd_en) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            case (byte_cnt)
              CNT_W'(0): byte0 <= in_dout;
              CNT_W'(1): byte1 <= in_dout;
              CNT_W'(2): byte2 <= in_dout;
              default: begin
                // Last Q byte comes straight from the FIFO head.
                i_din <= quantize({byte1, byte0});
                q_din <= quantize({in_dout, byte2});
                state <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (wr_go) begin
            sample_count <= sample_count + 32'd1;
            state        <= S_READ;
          end
        end
        default: state <= S_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_read_iq.sv
// tb_read_iq: randomized and directed stimulus for read_iq, checked every
// cycle against a queue-based reference model of the byte/pair stream.
module tb_read_iq;

  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = 8;
  localparam int unsigned BITS = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] in_dout;
  logic          in_empty;
  logic          in_rd_en;
  logic [DW-1:0] i_din;
  logic          i_wr_en;
  logic          i_full;
  logic [DW-1:0] q_din;
  logic          q_wr_en;
  logic          q_full;
  logic [31:0]   sample_count;

  read_iq #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .BITS(BITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_dout      (in_dout),
    .in_empty     (in_empty),
    .in_rd_en     (in_rd_en),
    .i_din        (i_din),
    .i_wr_en      (i_wr_en),
    .i_full       (i_full),
    .q_din        (q_din),
    .q_wr_en      (q_wr_en),
    .q_full       (q_full),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending input bytes, bytes of the group in progress,
  // last quantized pair, whether a pair awaits writing, and pairs written.
  logic [7:0]  byte_q[$];
  logic [7:0]  grp[$];
  logic [31:0] m_i = '0;
  logic [31:0] m_q = '0;
  logic [31:0] m_cnt = '0;
  bit          m_pend = 1'b0;
  int          cyc = 0;
  int          wr_cycles[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // 16-bit two's complement sample times 2^BITS, wrapped to 32 bits.
  function automatic logic [31:0] quant(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = int'(shortint'({hi, lo}));
    return 32'(v * (1 << BITS));
  endfunction

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    byte_q.push_back(b0);
    byte_q.push_back(b1);
    byte_q.push_back(b2);
    byte_q.push_back(b3);
  endtask

  // One clock: drive inputs after negedge, check, advance model, wait next negedge.
  task automatic step(input bit rst, input bit stall, input bit ifl, input bit qfl,
                      output bit wrote);
    bit exp_rd;
    bit exp_wr;
    reset    = rst;
    in_empty = stall || (byte_q.size() == 0);
    in_dout  = (byte_q.size() != 0) ? byte_q[0] : 8'($urandom);
    i_full   = ifl;
    q_full   = qfl;
    #1;
    exp_rd = !rst && !m_pend && !in_empty;
    exp_wr = !rst && m_pend && !ifl && !qfl;
    check("in_rd_en", 32'(in_rd_en), 32'(exp_rd));
    check("i_wr_en", 32'(i_wr_en), 32'(exp_wr));
    check("q_wr_en", 32'(q_wr_en), 32'(exp_wr));
    check("i_din", i_din, m_i);
    check("q_din", q_din, m_q);
    check("sample_count", sample_count, m_cnt);
    wrote = exp_wr;
    if (rst) begin
      grp.delete();
      m_pend = 1'b0;
      m_i    = '0;
      m_q    = '0;
      m_cnt  = '0;
    end else if (exp_rd) begin
      grp.push_back(byte_q.pop_front());
      if (grp.size() == 4) begin
        m_i    = quant(grp[0], grp[1]);
        m_q    = quant(grp[2], grp[3]);
        m_pend = 1'b1;
        grp.delete();
      end
    end else if (exp_wr) begin
      m_cnt  = m_cnt + 32'd1;
      m_pend = 1'b0;
      wr_cycles.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  // Run until n pairs are written (bounded), with random stalls and back-pressure.
  task automatic run_pairs(input int n, input int stall_pct, input int full_pct,
                           input string tag);
    int  got;
    bit  w;
    got = 0;
    for (int k = 0; k < 400 && got < n; k++) begin
      step(1'b0, $urandom_range(99) < stall_pct,
           $urandom_range(99) < full_pct, $urandom_range(99) < full_pct, w);
      if (w) got++;
    end
    check(tag, 32'(got), 32'(n));
  endtask

  task automatic idle(input int n, input bit stall, input bit qfl);
    bit w;
    for (int k = 0; k < n; k++) step(1'b0, stall, 1'b0, qfl, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit w;
    reset    = 1'b1;
    in_empty = 1'b1;
    in_dout  = '0;
    i_full   = 1'b0;
    q_full   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, held reset with data available.
    byte_q.push_back(8'h55);
    step(1'b1, 1'b0, 1'b0, 1'b0, w);
    step(1'b1, 1'b0, 1'b0, 1'b0, w);
    byte_q.delete();
    idle(3, 1'b0, 1'b0);

    // 1: basic group.
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    run_pairs(1, 0, 0, "s1_run");
    check("s1_i", i_din, 32'h0048D000);
    check("s1_q", q_din, 32'hFEAF3400);
    check("s1_cnt", sample_count, 32'd1);

    // 2: full-scale negative and positive.
    push4(8'h00, 8'h80, 8'hFF, 8'h7F);
    run_pairs(1, 0, 0, "s2_run");
    check("s2_i", i_din, 32'hFE000000);
    check("s2_q", q_din, 32'h01FFFC00);

    // 3: input starves mid-group.
    byte_q.push_back(8'h34);
    byte_q.push_back(8'h12);
    idle(3, 1'b0, 1'b0);
    idle(10, 1'b1, 1'b0);
    byte_q.push_back(8'hCD);
    byte_q.push_back(8'hAB);
    run_pairs(1, 0, 0, "s3_run");
    check("s3_i", i_din, 32'h0048D000);
    check("s3_q", q_din, 32'hFEAF3400);

    // 4: q_in FIFO back-pressure after a group is assembled.
    push4(8'h01, 8'h00, 8'hFE, 8'hFF);
    for (int k = 0; k < 10 && !m_pend; k++) step(1'b0, 1'b0, 1'b0, 1'b0, w);
    check("s4_pending", 32'(m_pend), 32'd1);
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    idle(6, 1'b0, 1'b1);
    check("s4_held_cnt", sample_count, 32'd3);
    run_pairs(1, 0, 0, "s4_run");
    check("s4_i", i_din, 32'h00000400);
    check("s4_q", q_din, 32'hFFFFF800);
    run_pairs(1, 0, 0, "s4_next");

    // 5: reset after two bytes of a group.
    byte_q.push_back(8'h77);
    byte_q.push_back(8'h66);
    idle(3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, w);
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    run_pairs(1, 0, 0, "s5_run");
    check("s5_i", i_din, 32'h0048D000);
    check("s5_q", q_din, 32'hFEAF3400);
    check("s5_cnt", sample_count, 32'd1);

    // 6: three back-to-back groups, 5-cycle spacing.
    step(1'b1, 1'b1, 1'b0, 1'b0, w);
    for (int g = 0; g < 3; g++)
      push4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    wr_cycles.delete();
    run_pairs(3, 0, 0, "s6_run");
    check("s6_cnt", sample_count, 32'd3);
    check("s6_writes", 32'(wr_cycles.size()), 32'd3);
    if (wr_cycles.size() == 3) begin
      check("s6_gap1", 32'(wr_cycles[1] - wr_cycles[0]), 32'd5);
      check("s6_gap2", 32'(wr_cycles[2] - wr_cycles[1]), 32'd5);
    end

    // 6b: counter wrap from a preset value.
    force dut.sample_count = 32'hFFFFFFFE;
    #1;
    release dut.sample_count;
    m_cnt = 32'hFFFFFFFE;
    push4(8'h10, 8'h20, 8'h30, 8'h40);
    push4(8'h50, 8'h60, 8'h70, 8'h80);
    run_pairs(1, 0, 0, "wrap_run1");
    check("wrap_max", sample_count, 32'hFFFFFFFF);
    run_pairs(1, 0, 0, "wrap_run2");
    check("wrap_zero", sample_count, 32'd0);

    // Random traffic with stalls and back-pressure.
    for (int g = 0; g < 40; g++)
      push4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    run_pairs(40, 30, 25, "rand_run");
    idle(4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_iq.md
Name: read_iq

Overview:
- Front-end stage of the FM radio pipeline. Consumes the raw byte stream of interleaved I/Q samples from an 8-bit input FIFO.
- Assembles each little-endian 16-bit I and Q sample and sign-extends it to DATA_WIDTH.
- Quantizes each sample by left-shifting BITS places.
- Pushes the I/Q pair simultaneously into the i_in and q_in sample FIFOs that feed fir_complex.

Parameters:
- DATA_WIDTH, 32, width of quantized I/Q output samples.
- BYTE_WIDTH, 8, width of input byte stream.
- BITS, 10, quantization shift (fixed-point fraction bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_dout  in  BYTE_WIDTH  byte at head of input FIFO (first-word-fall-through: valid whenever in_empty=0).
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  pop head byte of input FIFO this cycle.
- i_din  out  DATA_WIDTH  quantized I sample to i_in FIFO.
- i_wr_en  out  1  write i_din this cycle.
- i_full  in  1  i_in FIFO full.
- q_din  out  DATA_WIDTH  quantized Q sample to q_in FIFO.
- q_wr_en  out  1  write q_din this cycle.
- q_full  in  1  q_in FIFO full.
- sample_count  out  32  number of I/Q pairs written since reset.

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state is cleared on a rising clk edge with reset=1.
- Reset values: state=S_READ, byte_cnt=0, byte registers=0, i_din=0, q_din=0, sample_count=0.
- During reset cycles, in_rd_en, i_wr_en and q_wr_en are forced 0.
- Byte order per sample group: byte0=I[7:0], byte1=I[15:8], byte2=Q[7:0], byte3=Q[15:8].
- FSM has two states.
- S_READ:
  - in_rd_en = !in_empty (combinational).
  - When in_rd_en=1: in_dout is captured into byte register [byte_cnt], and byte_cnt increments.
  - When the byte with byte_cnt=3 is captured: byte_cnt wraps to 0 and the next state is S_WRITE.
  - The same edge registers:
    - i_din = sign_extend({byte1,byte0}) << BITS.
    - q_din = sign_extend({byte3,in_dout}) << BITS.
  - For these, sign-extend to DATA_WIDTH first, then shift. Bits shifted past DATA_WIDTH-1 are discarded; there is no saturation.
  - in_empty=1 stalls the block in S_READ with partial bytes held. There is no timeout.
- S_WRITE:
  - in_rd_en=0.
  - i_wr_en = q_wr_en = !i_full && !q_full (combinational). Both FIFOs are always written on the same cycle, never one alone.
  - On the write cycle: sample_count increments (wrapping at 2^32-1 -> 0) and the next state is S_READ.
  - If either FIFO is full, the block stays in S_WRITE. i_din/q_din are held stable and no bytes are consumed.
- Throughput: minimum 5 cycles per I/Q pair (4 read + 1 write). The first write enable is asserted 4 cycles after the first cycle with in_empty=0, given a continuously non-empty input.
- i_din/q_din change only on the S_READ->S_WRITE transition edge. They keep the last sample otherwise.
- Reset asserted mid-group (byte_cnt≠0) or in S_WRITE: the partial group/pending pair is dropped, and the next group starts from byte0 after reset.
- Simultaneous in_empty deassert and full deassert: irrelevant, because read and write never occur in the same cycle.

Test Plan:
1. Input bytes 0x34,0x12,0xCD,0xAB back-to-back, FIFOs not full -> 4 in_rd_en pulses. Next cycle: i_wr_en=q_wr_en=1, i_din=0x0048D000, q_din=0xFEAF3400, and sample_count becomes 1.
2. Bytes 0x00,0x80,0xFF,0x7F -> i_din=0xFE000000 (-32768<<10), q_din=0x01FFFC00 (32767<<10).
3. Input FIFO goes empty after 2 bytes for 10 cycles, then supplies 2 more -> no in_rd_en while empty, no write enable until the 4th byte. Output matches scenario 1 values for the same byte sequence.
4. q_full=1 held 6 cycles after group assembled -> i_wr_en=q_wr_en=0 throughout, in_rd_en=0, and i_din/q_din stable. A single write occurs on the first cycle both fulls are 0.
5. reset pulsed for 1 cycle after byte 2 of a group, then stream 0x34,0x12,0xCD,0xAB -> the partial group is discarded, the output is the scenario 1 pair, and sample_count=1.
6. 3 consecutive groups streamed continuously -> exactly 3 write pulses spaced 5 cycles apart, and sample_count=3. A sample_count preset near 0xFFFFFFFF (via force) wraps to 0.
